tmem_slave: RTL and testbench

Synthesizable tagged-memory responder for the CPU memory bus: the target end of the address/data/tag protocol the `cpu` module drives. It latches a word address on the address strobe, then serves reads and writes of a 64-bit word plus an 8-bit tag. It also enforces tag-based write protection and holds the address across atomic read-modify-write sequences. It replaces the behavioural bus model in FPGA builds and in system benches.

---
 rtl/tmem_pkg.sv | 16 +
 rtl/tmem_array.sv | 45 ++++
 rtl/tmem_slave.sv | 107 ++++++++++
 tb/tb_tmem_slave.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tmem_pkg.sv
// Shared types and constants for the tagged-memory responder.
package tmem_pkg;

  typedef struct packed {
    logic [7:0]  tag;
    logic [63:0] data;
  } tmem_word_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } tmem_state_t;

  localparam int unsigned WPROT_BIT_DEFAULT = 5;

endpackage

// File: rtl/tmem_array.sv
// Single-port write-first tagged RAM with a registered read port.
// Under TMEM_WPROT_EN it also exposes a combinational tag read for the protection check.
module tmem_array
  import tmem_pkg::*;
#(
  parameter int unsigned AW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr_i,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [71:0]   wdata_i,
  output logic [71:0]   rdata_o
`ifdef TMEM_WPROT_EN
  ,
  output logic [7:0]    tag_o
`endif
);

  tmem_word_t mem [2**AW];
  tmem_word_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  // Output register only moves on a read so the bus data holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= we_i ? tmem_word_t'(wdata_i) : mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

`ifdef TMEM_WPROT_EN
  assign tag_o = mem[addr_i].tag;
`endif

endmodule

// File: rtl/tmem_slave.sv
// Tagged-memory bus responder: address latch, atomic lock FSM, protection and protocol checks.
// Write protection is built only when TMEM_WPROT_EN is defined.
module tmem_slave
  import tmem_pkg::*;
#(
  parameter int unsigned AW        = 20,
  parameter int unsigned WPROT_BIT = WPROT_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_ad,
  input  logic [7:0]  i_tag,
  input  logic        i_astb,
  input  logic        i_atomic,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic        i_wforce,
  output logic [63:0] o_data,
  output logic [7:0]  o_tag,
  output logic        o_locked,
  output logic        o_wprot,
  output logic        o_perr
);

  tmem_state_t   state_q;
  logic [AW-1:0] waddr_q;
  logic          perr_q;

  logic          astb_ok;
  logic [AW-1:0] addr;
  logic          rd_req;
  logic          wr_req;
  logic          conflict;
  logic          blocked;
  logic          we;
  tmem_word_t    rd_word;

  assign astb_ok  = i_astb && (state_q == IDLE);
  assign addr     = astb_ok ? i_ad[AW-1:0] : waddr_q;
  assign rd_req   = i_rd && !i_wr;
  assign wr_req   = i_wr && !i_rd;
  assign conflict = i_rd && i_wr;
  assign we       = wr_req && !blocked;

`ifdef TMEM_WPROT_EN
  logic [7:0] stored_tag;
  logic       wprot_q;

  assign blocked = stored_tag[WPROT_BIT] && !i_wforce;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wprot_q <= 1'b0;
    end else begin
      wprot_q <= wr_req && blocked;
    end
  end

  assign o_wprot = wprot_q;
`else
  logic unused_cfg;

  assign blocked    = 1'b0;
  assign o_wprot    = 1'b0;
  assign unused_cfg = i_wforce ^ (WPROT_BIT == 0);
`endif

  tmem_array #(
    .AW (AW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .addr_i  (addr),
    .re_i    (rd_req),
    .we_i    (we),
    .wdata_i ({i_tag, i_ad}),
    .rdata_o (rd_word)
`ifdef TMEM_WPROT_EN
    ,
    .tag_o   (stored_tag)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      waddr_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      perr_q <= conflict || (rd_req && i_atomic && (state_q == LOCKED));
      if (astb_ok) begin
        waddr_q <= i_ad[AW-1:0];
      end
      unique case (state_q)
        IDLE:   if (rd_req && i_atomic) state_q <= LOCKED;
        LOCKED: if (wr_req) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data   = rd_word.data;
  assign o_tag    = rd_word.tag;
  assign o_locked = (state_q == LOCKED);
  assign o_perr   = perr_q;

endmodule

// File: tb/tb_tmem_slave.sv
// Directed bench for tmem_slave; expectations follow TMEM_WPROT_EN when defined.
module tb_tmem_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] i_ad;
  logic [7:0]  i_tag;
  logic        i_astb, i_atomic, i_rd, i_wr, i_wforce;
  logic [63:0] o_data;
  logic [7:0]  o_tag;
  logic        o_locked, o_wprot, o_perr;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

`ifdef TMEM_WPROT_EN
  localparam bit WprotEn = 1'b1;
`else
  localparam bit WprotEn = 1'b0;
`endif

  tmem_slave u_dut (
    .clk      (clk),
    .reset    (reset),
    .i_ad     (i_ad),
    .i_tag    (i_tag),
    .i_astb   (i_astb),
    .i_atomic (i_atomic),
    .i_rd     (i_rd),
    .i_wr     (i_wr),
    .i_wforce (i_wforce),
    .o_data   (o_data),
    .o_tag    (o_tag),
    .o_locked (o_locked),
    .o_wprot  (o_wprot),
    .o_perr   (o_perr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  task automatic idle();
    i_ad = '0; i_tag = '0; i_astb = 0; i_atomic = 0; i_rd = 0; i_wr = 0; i_wforce = 0;
  endtask

  // Advance one edge; checks run 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic strobe(input logic [63:0] a);
    i_astb = 1; i_ad = a;
    cyc();
  endtask

  task automatic wr(input logic [63:0] d, input logic [7:0] t, input logic force_w);
    i_wr = 1; i_ad = d; i_tag = t; i_wforce = force_w;
    cyc();
  endtask

  task automatic rd(input logic atomic);
    i_rd = 1; i_atomic = atomic;
    cyc();
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #3;
    check("reset o_data", o_data, 64'h0);
    check("reset o_tag", {56'h0, o_tag}, 64'h0);
    check("reset o_locked", {63'h0, o_locked}, 64'h0);
    check("reset o_wprot", {63'h0, o_wprot}, 64'h0);
    check("reset o_perr", {63'h0, o_perr}, 64'h0);
    reset = 0;
    @(posedge clk); #1;

    // Basic write/read
    strobe(64'h00123);
    wr(64'hDEADBEEF_01234567, 8'h35, 1'b1);
    rd(1'b0);
    check("basic data", o_data, 64'hDEADBEEF_01234567);
    check("basic tag", {56'h0, o_tag}, 64'h35);

    // Protection: same-cycle strobe + forced write of a protected tag
    i_astb = 1; i_ad = 64'h00040; i_wr = 1; i_tag = 8'h20; i_wforce = 1;
    i_ad = 64'h00040;
    cyc();
    wr(64'h1, 8'h00, 1'b0);
    check("wprot pulse", {63'h0, o_wprot}, {63'h0, WprotEn});
    cyc();
    check("wprot one cycle", {63'h0, o_wprot}, 64'h0);
    rd(1'b0);
    check("wprot data", o_data, WprotEn ? 64'h00040 : 64'h1);
    wr(64'h2, 8'h00, 1'b1);
    check("wforce no pulse", {63'h0, o_wprot}, 64'h0);
    rd(1'b0);
    check("wforce data", o_data, 64'h2);

    // Atomic lock freezes the address
    strobe(64'h00020);
    wr(64'h2020, 8'h00, 1'b1);
    strobe(64'h00010);
    wr(64'h1010, 8'h00, 1'b1);
    rd(1'b1);
    check("atomic locked", {63'h0, o_locked}, 64'h1);
    check("atomic data", o_data, 64'h1010);
    strobe(64'h00020);
    check("locked holds", {63'h0, o_locked}, 64'h1);
    wr(64'h7, 8'h00, 1'b1);
    check("unlock after write", {63'h0, o_locked}, 64'h0);
    rd(1'b0);
    check("atomic target", o_data, 64'h7);
    i_astb = 1; i_ad = 64'h00020; i_rd = 1;
    cyc();
    check("other untouched", o_data, 64'h2020);

    // Second atomic read while locked
    rd(1'b1);
    rd(1'b1);
    check("nested atomic perr", {63'h0, o_perr}, 64'h1);
    check("nested stays locked", {63'h0, o_locked}, 64'h1);
    cyc();
    check("nested perr one cycle", {63'h0, o_perr}, 64'h0);
    wr(64'h2020, 8'h00, 1'b1);

    // Protocol error: rd and wr together
    i_rd = 1; i_wr = 1; i_ad = 64'hBAD; i_wforce = 1;
    cyc();
    check("perr pulse", {63'h0, o_perr}, 64'h1);
    cyc();
    check("perr one cycle", {63'h0, o_perr}, 64'h0);
    rd(1'b0);
    check("perr no write", o_data, 64'h2020);

    // Reset mid-sequence
    i_astb = 1; i_ad = 64'h00030; i_rd = 1; i_atomic = 1;
    cyc();
    check("pre-reset locked", {63'h0, o_locked}, 64'h1);
    #2 reset = 1;
    #1;
    check("async reset unlock", {63'h0, o_locked}, 64'h0);
    check("async reset data", o_data, 64'h0);
    #2 reset = 0;
    i_astb = 1; i_ad = 64'h00123; i_rd = 1;
    cyc();
    check("post-reset strobe", o_data, 64'hDEADBEEF_01234567);

    // Top address, read-after-write next cycle
    strobe(64'hFFFFF);
    wr(64'hA, 8'h00, 1'b1);
    rd(1'b0);
    check("raw top addr", o_data, 64'hA);

    // Address wrap
    strobe(64'h00005);
    wr(64'h55, 8'h00, 1'b1);
    strobe(64'h1_00005);
    rd(1'b0);
    check("wrap read", o_data, 64'h55);
    check("wrap no perr", {63'h0, o_perr}, 64'h0);
    wr(64'h66, 8'h00, 1'b1);
    i_astb = 1; i_ad = 64'h00005; i_rd = 1;
    cyc();
    check("wrap write", o_data, 64'h66);

    // Back-to-back reads
    i_astb = 1; i_ad = 64'h00010; i_rd = 1;
    cyc();
    check("b2b first", o_data, 64'h7);
    i_astb = 1; i_ad = 64'hFFFFF; i_rd = 1;
    cyc();
    check("b2b second", o_data, 64'hA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
